// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble game blocks.
//   game_state_t : level sequencer states, encoding is exported on gameState
//   SIZE_*       : bubble size codes carried on popSize
//   MAX_BUBBLES  : number of bubble instances in bubble_array
package bubble_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SPAWN_WAIT  = 3'd1,
    ST_PLAYING     = 3'd2,
    ST_DYING       = 3'd3,
    ST_LEVEL_CLEAR = 3'd4,
    ST_GAME_OVER   = 3'd5,
    ST_WIN         = 3'd6
  } game_state_t;

  localparam logic [2:0] SIZE_LARGE  = 3'd3;
  localparam logic [2:0] SIZE_SMALL  = 3'd1;
  localparam int         MAX_BUBBLES = 7;

endpackage

// File: rtl/bubble_level_ctrl_frame_delay_counter.sv
// frame_delay_counter: counts startOfFrame pulses and flags the pulse that
// completes a delay of `delay` frames.
//   clk, resetN   : clock, async active-low reset
//   clear         : restart the count from zero (wins over counting)
//   startOfFrame  : count enable, one pulse per frame (already gated by caller)
//   delay         : delay length in frames, 1..127
//   expired       : high on the frame pulse where count == delay-1
module frame_delay_counter
  import bubble_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       startOfFrame,
  input  logic [6:0] delay,
  output logic       expired
);

  logic [6:0] cnt_q, cnt_d;

  assign expired = startOfFrame && (cnt_q == delay - 7'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)             cnt_d = '0;
    else if (startOfFrame) cnt_d = cnt_q + 7'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bubble_level_ctrl.sv
// bubble_level_ctrl: game-level sequencer for the bubble array.
//   clk, resetN   : clock, async active-low reset
//   startOfFrame  : one pulse per video frame
//   startGame     : start / restart request
//   popEvent      : a bubble was hit, popSize gives its size
//   playerHit     : a bubble touched the player
//   spawnStart    : one-cycle start pulse to bubble_array
//   clearBubbles  : one-cycle pulse deactivating all bubbles
//   freeze        : objects must not move (any state but PLAYING)
//   level, lives, aliveCount, gameState : status for HUD/sound
//
// state       | meaning
// IDLE        | after reset, waiting for startGame
// SPAWN_WAIT  | frozen countdown before the level spawns
// PLAYING     | level running, pops/hits tracked
// DYING       | player hit, death countdown
// LEVEL_CLEAR | all bubbles gone, countdown to next level
// GAME_OVER   | no lives left, waiting for startGame
// WIN         | last level cleared, waiting for startGame
module bubble_level_ctrl
  import bubble_pkg::*;
#(
  parameter int MAX_LEVEL          = 4,
  parameter int START_LIVES        = 3,
  parameter int SPAWN_DELAY_FRAMES = 30,
  parameter int CLEAR_DELAY_FRAMES = 60,
  parameter int DEATH_DELAY_FRAMES = 45
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       popEvent,
  input  logic [2:0] popSize,
  input  logic       playerHit,
  output logic       spawnStart,
  output logic       clearBubbles,
  output logic       freeze,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic [3:0] aliveCount,
  output logic [2:0] gameState
);

  localparam logic [2:0] LAST_LEVEL = 3'(MAX_LEVEL);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [6:0] SPAWN_D    = 7'(SPAWN_DELAY_FRAMES);
  localparam logic [6:0] CLEAR_D    = 7'(CLEAR_DELAY_FRAMES);
  localparam logic [6:0] DEATH_D    = 7'(DEATH_DELAY_FRAMES);

  game_state_t state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  alive_q, alive_d;
  logic        spawn_q, spawn_d;
  logic        clear_q, clear_d;

  logic        wait_state;
  logic [6:0]  delay_sel;
  logic        expired;

  always_comb begin
    wait_state = 1'b1;
    delay_sel  = SPAWN_D;
    case (state_q)
      ST_SPAWN_WAIT:  delay_sel = SPAWN_D;
      ST_DYING:       delay_sel = DEATH_D;
      ST_LEVEL_CLEAR: delay_sel = CLEAR_D;
      default:        wait_state = 1'b0;
    endcase
  end

  // Any state change restarts the frame count, so every wait state
  // begins counting from zero.
  frame_delay_counter u_delay (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (state_d != state_q),
    .startOfFrame (startOfFrame && wait_state),
    .delay        (delay_sel),
    .expired      (expired)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    alive_d = alive_q;
    spawn_d = 1'b0;
    clear_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER, ST_WIN: begin
        if (startGame) begin
          state_d = ST_SPAWN_WAIT;
          level_d = 3'd1;
          lives_d = LIVES_INIT;
          alive_d = '0;
          clear_d = 1'b1;
        end
      end

      ST_SPAWN_WAIT: begin
        if (expired) begin
          state_d = ST_PLAYING;
          spawn_d = 1'b1;
          alive_d = 4'd1;
        end
      end

      ST_PLAYING: begin
        if (playerHit) begin
          state_d = ST_DYING;
        end else if (popEvent && (alive_q != 4'd0)) begin
          // Size 0 is malformed and treated like the smallest bubble.
          if (popSize > SIZE_SMALL) begin
            if (alive_q != 4'hF) alive_d = alive_q + 4'd1;
          end else begin
            alive_d = alive_q - 4'd1;
            if (alive_q == 4'd1) state_d = ST_LEVEL_CLEAR;
          end
        end
      end

      ST_DYING: begin
        if (expired) begin
          clear_d = 1'b1;
          alive_d = '0;
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = ST_SPAWN_WAIT;
          end else begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end
        end
      end

      ST_LEVEL_CLEAR: begin
        if (expired) begin
          if (level_q == LAST_LEVEL) begin
            state_d = ST_WIN;
          end else begin
            level_d = level_q + 3'd1;
            clear_d = 1'b1;
            state_d = ST_SPAWN_WAIT;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      level_q <= 3'd1;
      lives_q <= LIVES_INIT;
      alive_q <= '0;
      spawn_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      alive_q <= alive_d;
      spawn_q <= spawn_d;
      clear_q <= clear_d;
    end
  end

  assign spawnStart   = spawn_q;
  assign clearBubbles = clear_q;
  assign freeze       = (state_q != ST_PLAYING);
  assign level        = level_q;
  assign lives        = lives_q;
  assign aliveCount   = alive_q;
  assign gameState    = state_q;

endmodule

// File: tb/tb_bubble_level_ctrl.sv
module tb_bubble_level_ctrl;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       startGame;
  logic       popEvent;
  logic [2:0] popSize;
  logic       playerHit;
  logic       spawnStart;
  logic       clearBubbles;
  logic       freeze;
  logic [2:0] level;
  logic [1:0] lives;
  logic [3:0] aliveCount;
  logic [2:0] gameState;

  int errors  = 0;
  int checks  = 0;
  int n_spawn = 0;
  int n_clear = 0;
  int overlap = 0;

  bubble_level_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startGame    (startGame),
    .popEvent     (popEvent),
    .popSize      (popSize),
    .playerHit    (playerHit),
    .spawnStart   (spawnStart),
    .clearBubbles (clearBubbles),
    .freeze       (freeze),
    .level        (level),
    .lives        (lives),
    .aliveCount   (aliveCount),
    .gameState    (gameState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, pulses tallied.
  task automatic tick();
    @(posedge clk);
    #1;
    if (spawnStart === 1'b1) n_spawn++;
    if (clearBubbles === 1'b1) n_clear++;
    if (spawnStart === 1'b1 && clearBubbles === 1'b1) overlap++;
  endtask

  // n frames, one startOfFrame pulse every 4 cycles; pulse tallies restart.
  task automatic frames(input int n);
    n_spawn = 0;
    n_clear = 0;
    for (int f = 0; f < n; f++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
      tick();
    end
  endtask

  task automatic pop(input logic [2:0] sz);
    popEvent = 1'b1;
    popSize  = sz;
    tick();
    popEvent = 1'b0;
    popSize  = 3'd0;
  endtask

  task automatic start_game();
    n_clear = 0;
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
  endtask

  task automatic hit();
    playerHit = 1'b1;
    tick();
    playerHit = 1'b0;
  endtask

  logic [2:0] sizes [7] = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
  logic [3:0] alives[7] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; startGame = 1'b0;
    popEvent = 1'b0; popSize = 3'd0; playerHit = 1'b0;
    repeat (3) tick();
    chk("rst_state", gameState, 0);
    chk("rst_level", level, 1);
    chk("rst_lives", lives, 3);
    chk("rst_alive", aliveCount, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_spawn", spawnStart, 0);
    chk("rst_clear", clearBubbles, 0);
    resetN = 1'b1;
    tick();

    // Start and spawn level 1
    start_game();
    chk("start_state", gameState, 1);
    chk("start_clear", n_clear, 1);
    tick();
    chk("start_clear_1cyc", clearBubbles, 0);
    frames(29);
    chk("spawn29_state", gameState, 1);
    chk("spawn29_pulse", n_spawn, 0);
    frames(1);
    chk("spawn_pulse", n_spawn, 1);
    chk("spawn_state", gameState, 2);
    chk("spawn_alive", aliveCount, 1);
    chk("spawn_freeze", freeze, 0);

    // Full level 1
    for (int i = 0; i < 7; i++) begin
      pop(sizes[i]);
      chk($sformatf("pop%0d_alive", i), aliveCount, alives[i]);
    end
    chk("lvl1_clear_state", gameState, 4);
    frames(60);
    chk("lvl2_level", level, 2);
    chk("lvl2_clear", n_clear, 1);
    chk("lvl2_state", gameState, 1);

    // Hit and pop together: hit wins
    frames(30);
    chk("lvl2_play", gameState, 2);
    playerHit = 1'b1; popEvent = 1'b1; popSize = 3'd1;
    tick();
    playerHit = 1'b0; popEvent = 1'b0; popSize = 3'd0;
    chk("hitpop_state", gameState, 3);
    chk("hitpop_alive", aliveCount, 1);
    chk("hitpop_freeze", freeze, 1);
    frames(45);
    chk("death1_lives", lives, 2);
    chk("death1_state", gameState, 1);
    chk("death1_level", level, 2);
    chk("death1_clear", n_clear, 1);

    // Ignored inputs outside PLAYING
    pop(3'd3);
    chk("spawnwait_pop_ign", aliveCount, 0);
    start_game();
    chk("spawnwait_start_ign", gameState, 1);
    chk("spawnwait_start_noclr", n_clear, 0);

    // Saturation and size-0 handling, then second death
    frames(30);
    for (int i = 0; i < 16; i++) pop(3'd3);
    chk("sat_alive", aliveCount, 15);
    pop(3'd0);
    chk("size0_alive", aliveCount, 14);
    hit();
    frames(45);
    chk("death2_lives", lives, 1);
    chk("death2_state", gameState, 1);

    // Third death -> GAME_OVER
    frames(30);
    hit();
    frames(45);
    chk("death3_lives", lives, 0);
    chk("death3_state", gameState, 5);
    chk("death3_freeze", freeze, 1);
    chk("death3_clear", n_clear, 1);

    // Restart from GAME_OVER
    start_game();
    chk("restart_state", gameState, 1);
    chk("restart_level", level, 1);
    chk("restart_lives", lives, 3);
    chk("restart_clear", n_clear, 1);

    // Clear all four levels
    for (int l = 1; l <= 4; l++) begin
      frames(30);
      chk($sformatf("l%0d_level", l), level, l);
      pop(3'd1);
      chk($sformatf("l%0d_cleared", l), gameState, 4);
      frames(60);
      chk($sformatf("l%0d_clear_pulses", l), n_clear, (l == 4) ? 0 : 1);
    end
    chk("win_state", gameState, 6);
    chk("win_level", level, 4);
    pop(3'd3);
    chk("win_pop_ign", aliveCount, 0);
    chk("win_freeze", freeze, 1);

    // Reset mid SPAWN_WAIT
    start_game();
    frames(10);
    resetN = 1'b0;
    #3;
    chk("midrst_state", gameState, 0);
    chk("midrst_level", level, 1);
    chk("midrst_lives", lives, 3);
    chk("midrst_alive", aliveCount, 0);
    chk("midrst_spawn", spawnStart, 0);
    chk("midrst_clear", clearBubbles, 0);
    tick();
    resetN = 1'b1;
    frames(40);
    chk("midrst_no_spawn", n_spawn, 0);
    chk("midrst_idle", gameState, 0);

    chk("pulse_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
